// File: rtl/haz_pkg.sv
// haz_pkg: shared types for the hazard/forwarding controller (HAZ_FWD_EN selects forwarding).
package haz_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_e;
  typedef enum logic [1:0] {RUN, LDUSE, MEMWAIT} haz_state_e;
  typedef struct packed {
    logic valid;
    logic wen;
    logic load;
    logic mem;
  } stage_info_t;
endpackage

// File: rtl/haz_fwd_sel.sv
// haz_fwd_sel: combinational operand-select for one EX source; MEM beats WB, x0 never forwards.
module haz_fwd_sel
  import haz_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              mem_fwd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_fwd,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        sel
);
  always_comb
    sel = !(|rs) ? FWD_RF : (mem_fwd && mem_rd == rs) ? FWD_MEM : (wb_fwd && wb_rd == rs) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: load-use stall, branch flush and dmem freeze sequencing with EX operand forwarding.
// Build with HAZ_FWD_EN for forwarding; without it every RAW dependency stalls until writeback retires.
module hazard_fwd_ctrl
  import haz_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_rs1_use,
  input  logic              i_id_rs2_use,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_id_regwen,
  input  logic              i_id_is_load,
  input  logic              i_id_is_mem,
  input  logic              i_ex_br_taken,
  input  logic              i_dmem_ready,
  output logic [SEL_W-1:0]  opa_sel,
  output logic [SEL_W-1:0]  opb_sel,
  output logic              o_stall_if,
  output logic              o_stall_id,
  output logic              o_stall_ex,
  output logic              o_flush_id,
  output logic              o_flush_ex
);
  haz_state_e state, state_n;
  stage_info_t ex, mem;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic wb_valid, wb_wen;
  logic freeze, hold, flush, bubble, hazard;
  assign bubble = flush | hold;
`ifdef HAZ_FWD_EN
  logic [REG_AW-1:0] ex_rs1, ex_rs2;
  logic [1:0] sel_a, sel_b;
  assign hazard = ex.valid & ex.load & ex.wen & i_id_valid &
                  ((i_id_rs1_use & i_id_rs1 == ex_rd) | (i_id_rs2_use & i_id_rs2 == ex_rd));
  haz_fwd_sel #(.REG_AW(REG_AW)) u_sel_a (
    .rs(ex_rs1), .mem_fwd(mem.valid & mem.wen & !mem.load), .mem_rd(mem_rd),
    .wb_fwd(wb_valid & wb_wen), .wb_rd(wb_rd), .sel(sel_a)
  );
  haz_fwd_sel #(.REG_AW(REG_AW)) u_sel_b (
    .rs(ex_rs2), .mem_fwd(mem.valid & mem.wen & !mem.load), .mem_rd(mem_rd),
    .wb_fwd(wb_valid & wb_wen), .wb_rd(wb_rd), .sel(sel_b)
  );
  assign opa_sel = SEL_W'(sel_a);
  assign opb_sel = SEL_W'(sel_b);
  // Unread or bubbled sources capture x0 so they can never pick up a forward.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      ex_rs1 <= '0;
      ex_rs2 <= '0;
    end else if (!freeze) begin
      ex_rs1 <= (i_id_valid & i_id_rs1_use & !bubble) ? i_id_rs1 : '0;
      ex_rs2 <= (i_id_valid & i_id_rs2_use & !bubble) ? i_id_rs2 : '0;
    end
`else
  logic hit1, hit2;
  assign hit1 = i_id_rs1_use & ((ex.valid & ex.wen & ex_rd == i_id_rs1) |
                                (mem.valid & mem.wen & mem_rd == i_id_rs1) |
                                (wb_valid & wb_wen & wb_rd == i_id_rs1));
  assign hit2 = i_id_rs2_use & ((ex.valid & ex.wen & ex_rd == i_id_rs2) |
                                (mem.valid & mem.wen & mem_rd == i_id_rs2) |
                                (wb_valid & wb_wen & wb_rd == i_id_rs2));
  assign hazard  = i_id_valid & (hit1 | hit2);
  assign opa_sel = '0;
  assign opb_sel = '0;
`endif
  always_comb begin
    freeze = !i_rst & !i_dmem_ready & (state == MEMWAIT | (mem.valid & mem.mem));
    flush = !i_rst & !freeze & i_ex_br_taken;
    hold = !i_rst & !freeze & !i_ex_br_taken & hazard;
    o_stall_if = freeze | hold;
    o_stall_id = freeze | hold;
    o_stall_ex = freeze;
    o_flush_id = flush;
    o_flush_ex = flush | hold;
`ifdef HAZ_FWD_EN
    state_n = freeze ? MEMWAIT : hold ? LDUSE : RUN;
`else
    state_n = freeze ? MEMWAIT : RUN;
`endif
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= RUN;
      ex <= '0;
      mem <= '0;
      ex_rd <= '0;
      mem_rd <= '0;
      wb_rd <= '0;
      wb_valid <= 1'b0;
      wb_wen <= 1'b0;
    end else begin
      state <= state_n;
      if (!freeze) begin
        ex <= bubble ? '0 : {i_id_valid, i_id_regwen & (|i_id_rd), i_id_is_load, i_id_is_mem};
        ex_rd <= i_id_rd;
        mem <= ex;
        mem_rd <= ex_rd;
        wb_valid <= mem.valid;
        wb_wen <= mem.wen;
        wb_rd <= mem_rd;
      end
    end
endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
Hazard and forwarding controller for the 5-stage pipeline. It drives the EX-stage operand-select muxes (`opa_sel`/`opb_sel`) and the pipeline stall/flush controls.
It keeps its own shadow copy of the per-stage destination and source register info (ID→EX→MEM→WB). It sequences load-use stalls, taken-branch flushes and data-memory wait freezes.

Parameters:
- REG_AW, 5, register-index width
- SEL_W, 2, width of operand-select codes

Ports:
- i_clk  input  1  pipeline clock
- i_rst  input  1  asynchronous, active-high reset
- i_id_valid  input  1  ID holds a real instruction
- i_id_rs1  input  REG_AW  ID source 1 index
- i_id_rs2  input  REG_AW  ID source 2 index
- i_id_rs1_use  input  1  ID instruction reads rs1
- i_id_rs2_use  input  1  ID instruction reads rs2
- i_id_rd  input  REG_AW  ID destination index
- i_id_regwen  input  1  ID instruction writes rd
- i_id_is_load  input  1  ID instruction is a load
- i_id_is_mem  input  1  ID instruction is a load or store
- i_ex_br_taken  input  1  EX resolved a taken branch or jump
- i_dmem_ready  input  1  data memory completes the access in MEM this cycle
- opa_sel  output  SEL_W  EX rs1 mux select: 00 regfile, 01 WB data, 10 MEM-stage ALU data
- opb_sel  output  SEL_W  EX rs2 mux select, same encoding as opa_sel
- o_stall_if  output  1  hold PC
- o_stall_id  output  1  hold IF/ID register
- o_stall_ex  output  1  hold ID/EX and EX/MEM registers
- o_flush_id  output  1  zero IF/ID register
- o_flush_ex  output  1  load bubble into ID/EX register

Behaviour:
- Shadow slots:
  - EX{valid, rs1, rs2, rd, wen, load, mem}, MEM{valid, rd, wen, load, mem}, WB{valid, rd, wen}.
  - They advance every cycle unless frozen.
  - rd==0 is treated as wen=0 on capture.
- Reset (async, i_rst=1):
  - All slots invalid; FSM=RUN.
  - opa_sel=opb_sel=00; all stall and flush outputs 0.
- Forwarding (combinational from registered slots, zero latency):
  - opa_sel=10 if MEM.valid & MEM.wen & !MEM.load & MEM.rd==EX.rs1.
  - Else opa_sel=01 if WB.valid & WB.wen & WB.rd==EX.rs1.
  - Else opa_sel=00.
  - opb_sel is the same logic using EX.rs2.
  - The MEM stage has priority over WB.
  - Index 0 never forwards.
  - Code 11 is never produced.
- FSM states: RUN, LDUSE, MEMWAIT.
  - RUN→MEMWAIT when MEM.valid & MEM.mem & !i_dmem_ready. Outputs: all stalls=1, slots frozen, flushes=0.
  - MEMWAIT→RUN on the first cycle with i_dmem_ready=1. That cycle the pipeline advances normally.
  - RUN→LDUSE when EX.valid & EX.load & EX.wen & i_id_valid & ((rs1_use & rs1==EX.rd) | (rs2_use & rs2==EX.rd)). Outputs: o_stall_if=o_stall_id=1, o_flush_ex=1, EX slot captures a bubble.
  - LDUSE→RUN unconditionally next cycle. Exactly one stall cycle; the load is then in WB-forward range (01).
- Branch flush: i_ex_br_taken in RUN or LDUSE → o_flush_id=o_flush_ex=1 for one cycle; the EX slot captures a bubble.
- Priority: MEMWAIT freeze > branch flush > load-use stall.
  - Branch with load-use: the branch wins and no stall occurs.
  - Branch during a freeze: ignored until the freeze ends; the EX slot is held, so the branch is re-sampled.
- Reset mid-stall or mid-freeze returns to RUN with all slots invalid.

Optional Feature:
- Macro HAZ_FWD_EN.
- Defined: forwarding as above.
- Undefined:
  - opa_sel=opb_sel=00 always.
  - Any ID source matching a valid writing EX, MEM or WB slot stalls IF/ID and bubbles EX.
  - The regfile has no write-through, so a WB match also stalls.
  - The stall is repeated each cycle until no match; the LDUSE state is unused.

Decomposition:
- Package haz_pkg:
  - Enum fwd_sel_e {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}.
  - Enum haz_state_e {RUN, LDUSE, MEMWAIT}.
  - Packed struct stage_info_t for the shadow slots.
- One sub-module: haz_fwd_sel, the pure combinational select generator, instantiated twice (rs1 and rs2).

Test Plan:
- `addi x5`, then `add x6,x5,x1` back-to-back → at `add` in EX, opa_sel=10, no stall.
- `addi x5`, nop, `add x6,x5,x5` → opa_sel=opb_sel=01.
- `lw x7`, then `add x8,x7,x0` → one cycle of o_stall_if=o_stall_id=o_flush_ex=1; next cycle opa_sel=01; opb_sel=00 (x0 never forwarded).
- `beq` taken in EX while ID holds a load-use dependent → o_flush_id=o_flush_ex=1 for 1 cycle, no stall.
- `sw` in MEM with i_dmem_ready low for 3 cycles → all stalls=1 for exactly 3 cycles; selects unchanged; RUN on ready.
- i_rst pulsed mid-MEMWAIT → outputs immediately 00/0, FSM RUN; build without HAZ_FWD_EN: `addi x5`, `add x6,x5` → 3 stall cycles, selects stay 00.
